board_controller: RTL and testbench

Sequencer for the cellular-automaton board array. It accepts commands over a valid/ready interface: clear, load pattern, step N generations, run, and stop. It drives the board's `simClock`, `load`, `reset` and `enTimeStep` inputs and presents the load pattern. It also counts generations and detects when the board has stopped changing. It sits between the host/UART command path and the board instance.

---
 rtl/board_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_board_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_controller.sv
// Command sequencer for the cellular-automaton board: clear, load, step, run and stop.
// Define BOARD_CTRL_STABLE_STOP_EN to end STEP/RUN automatically once the board stops changing.
module board_controller #(
  parameter int LENGTH    = 3,
  parameter int HEIGHT    = 3,
  parameter int DIV_WIDTH = 24,
  parameter int GEN_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmdValid,
  output logic                         cmdReady,
  input  logic [2:0]                   cmdOp,
  input  logic [GEN_WIDTH-1:0]         cmdArg,
  input  logic [DIV_WIDTH-1:0]         period,
  input  logic [LENGTH*HEIGHT*2-1:0]   patternIn,
  input  logic [LENGTH*HEIGHT-1:0]     boardOut,
  output logic                         simClock,
  output logic                         load,
  output logic                         boardReset,
  output logic                         enTimeStep,
  output logic [LENGTH*HEIGHT*2-1:0]   loadVals,
  output logic [GEN_WIDTH-1:0]         generation,
  output logic                         busy,
  output logic                         stepDone,
  output logic                         stable
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_TICK   = 3'd4,
    ST_SETTLE = 3'd5
  } state_t;

  localparam logic [2:0] OP_CLEAR = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STEP  = 3'd3;
  localparam logic [2:0] OP_RUN   = 3'd4;
  localparam logic [2:0] OP_STOP  = 3'd5;

  localparam logic [DIV_WIDTH-1:0] CNT_ONE    = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] CNT_TWO    = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] MIN_PERIOD = DIV_WIDTH'(3);
  localparam logic [GEN_WIDTH-1:0] GEN_ONE    = GEN_WIDTH'(1);

`ifdef BOARD_CTRL_STABLE_STOP_EN
  localparam logic STABLE_STOP = 1'b1;
`else
  localparam logic STABLE_STOP = 1'b0;
`endif

  state_t                        state_r, state_s;
  logic [DIV_WIDTH-1:0]          cnt_r, cnt_s;
  logic [DIV_WIDTH-1:0]          eff_period_r, eff_period_s;
  logic [GEN_WIDTH-1:0]          remaining_r, remaining_s;
  logic                          run_mode_r, run_mode_s;
  logic                          stop_pend_r, stop_pend_s;
  logic [LENGTH*HEIGHT-1:0]      snapshot_r, snapshot_s;
  logic [LENGTH*HEIGHT*2-1:0]    load_vals_r, load_vals_s;
  logic [GEN_WIDTH-1:0]          generation_r, generation_s;
  logic                          stable_r, stable_s;
  logic                          step_done_r, step_done_s;
  logic                          sim_clock_r, load_r, board_reset_r, en_time_step_r, busy_r;
  logic                          running_s, accept_s, stop_acc_s, tick_due_s, last_s, equal_s;

  assign running_s  = (state_r == ST_WAIT) || (state_r == ST_TICK) || (state_r == ST_SETTLE);
  assign cmdReady   = (state_r == ST_IDLE) || (running_s && (cmdOp == OP_STOP));
  assign accept_s   = cmdValid && cmdReady;
  assign stop_acc_s = accept_s && running_s;
  // WAIT keeps counting through TICK/SETTLE, so the next tick lands exactly eff_period after the last
  assign tick_due_s = (cnt_r == (eff_period_r - CNT_ONE));
  assign last_s     = !run_mode_r && (remaining_r == GEN_ONE);
  assign equal_s    = (boardOut == snapshot_r);

  // Next-state and next-register computation
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r + CNT_ONE;
    eff_period_s = eff_period_r;
    remaining_s  = remaining_r;
    run_mode_s   = run_mode_r;
    stop_pend_s  = stop_pend_r;
    snapshot_s   = snapshot_r;
    load_vals_s  = load_vals_r;
    generation_s = generation_r;
    stable_s     = stable_r;
    step_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmdOp)
            OP_CLEAR: begin
              state_s      = ST_CLEAR;
              cnt_s        = '0;
              generation_s = '0;
              stable_s     = 1'b0;
            end
            OP_LOAD: begin
              state_s      = ST_LOAD;
              cnt_s        = '0;
              load_vals_s  = patternIn;
              generation_s = '0;
            end
            OP_STEP, OP_RUN: begin
              if ((cmdOp == OP_STEP) && (cmdArg == '0)) begin
                state_s     = ST_IDLE;
                step_done_s = 1'b1;
              end else begin
                state_s      = ST_WAIT;
                cnt_s        = CNT_ONE;
                eff_period_s = (period < MIN_PERIOD) ? MIN_PERIOD : period;
                remaining_s  = cmdArg;
                run_mode_s   = (cmdOp == OP_RUN);
                stop_pend_s  = 1'b0;
              end
            end
            default: state_s = ST_IDLE;
          endcase
        end else begin
          cnt_s = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == CNT_ONE) state_s = ST_IDLE;
        else state_s = ST_CLEAR;
      end
      ST_LOAD: begin
        if (cnt_r == CNT_TWO) state_s = ST_IDLE;
        else state_s = ST_LOAD;
      end
      ST_WAIT: begin
        if (stop_acc_s) begin
          state_s     = ST_IDLE;
          step_done_s = 1'b1;
        end else if (tick_due_s) begin
          state_s = ST_TICK;
          cnt_s   = '0;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_TICK: begin
        state_s      = ST_SETTLE;
        snapshot_s   = boardOut;
        generation_s = generation_r + GEN_ONE;
        if (stop_acc_s) stop_pend_s = 1'b1;
        else stop_pend_s = stop_pend_r;
      end
      ST_SETTLE: begin
        if (cnt_r == CNT_TWO) begin
          stable_s = equal_s;
          if (!run_mode_r) remaining_s = remaining_r - GEN_ONE;
          else remaining_s = remaining_r;
          if (last_s || stop_pend_r || stop_acc_s || (STABLE_STOP && equal_s)) begin
            state_s     = ST_IDLE;
            step_done_s = 1'b1;
          end else if (tick_due_s) begin
            state_s = ST_TICK;
            cnt_s   = '0;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_SETTLE;
          if (stop_acc_s) stop_pend_s = 1'b1;
          else stop_pend_s = stop_pend_r;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State and registered outputs; board controls are decoded from the next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= '0;
      eff_period_r   <= '0;
      remaining_r    <= '0;
      run_mode_r     <= 1'b0;
      stop_pend_r    <= 1'b0;
      snapshot_r     <= '0;
      load_vals_r    <= '0;
      generation_r   <= '0;
      stable_r       <= 1'b0;
      step_done_r    <= 1'b0;
      sim_clock_r    <= 1'b0;
      load_r         <= 1'b0;
      board_reset_r  <= 1'b0;
      en_time_step_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      eff_period_r   <= eff_period_s;
      remaining_r    <= remaining_s;
      run_mode_r     <= run_mode_s;
      stop_pend_r    <= stop_pend_s;
      snapshot_r     <= snapshot_s;
      load_vals_r    <= load_vals_s;
      generation_r   <= generation_s;
      stable_r       <= stable_s;
      step_done_r    <= step_done_s;
      sim_clock_r    <= (state_s == ST_TICK) || ((state_s == ST_LOAD) && (cnt_s == CNT_ONE));
      load_r         <= (state_s == ST_LOAD);
      board_reset_r  <= (state_s == ST_CLEAR);
      en_time_step_r <= (state_s == ST_WAIT) || (state_s == ST_TICK) || (state_s == ST_SETTLE);
      busy_r         <= (state_s != ST_IDLE);
    end
  end

  assign simClock   = sim_clock_r;
  assign load       = load_r;
  assign boardReset = board_reset_r;
  assign enTimeStep = en_time_step_r;
  assign loadVals   = load_vals_r;
  assign generation = generation_r;
  assign busy       = busy_r;
  assign stepDone   = step_done_r;
  assign stable     = stable_r;

endmodule

// File: tb/tb_board_controller.sv
// Self-checking bench for board_controller: tick timing table, hand sequences, and a random
// command stream checked against a cycle-arithmetic reference model.
module tb_board_controller;
  localparam int DW = 24;
  localparam int GW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmdValid = 1'b0;
  logic          cmdReady;
  logic [2:0]    cmdOp = 3'd0;
  logic [GW-1:0] cmdArg = '0;
  logic [DW-1:0] period = '0;
  logic [17:0]   patternIn = 18'd0;
  logic [8:0]    boardOut = 9'd0;
  logic          simClock, load, boardReset, enTimeStep, busy, stepDone, stable;
  logic [17:0]   loadVals;
  logic [GW-1:0] generation;

  board_controller #(.LENGTH(3), .HEIGHT(3), .DIV_WIDTH(DW), .GEN_WIDTH(GW)) dut (
    .clock(clock), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdArg(cmdArg), .period(period), .patternIn(patternIn),
    .boardOut(boardOut), .simClock(simClock), .load(load), .boardReset(boardReset),
    .enTimeStep(enTimeStep), .loadVals(loadVals), .generation(generation),
    .busy(busy), .stepDone(stepDone), .stable(stable)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Toy board: every tick changes the state unless it is a still life
  bit still_mode = 1'b0;
  always @(posedge clock) if (simClock && !still_mode) boardOut <= boardOut + 9'd1;

  int tick_q[$], done_q[$], load_q[$], brst_q[$];
  always @(negedge clock) begin
    if (simClock)   tick_q.push_back(cyc);
    if (stepDone)   done_q.push_back(cyc);
    if (load)       load_q.push_back(cyc);
    if (boardReset) brst_q.push_back(cyc);
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_q();
    tick_q.delete(); done_q.delete(); load_q.delete(); brst_q.delete();
  endtask

  task automatic send(input logic [2:0] op, input int arg, input int per,
                      input logic [17:0] pat, output int acc);
    @(posedge clock); #1;
    cmdValid = 1'b1; cmdOp = op; cmdArg = GW'(arg); period = DW'(per); patternIn = pat;
    #1;
    for (int i = 0; i < 2000 && !cmdReady; i++) begin
      @(posedge clock); #2;
    end
    if (!cmdReady) chk("accept_timeout", 0, 1);
    acc = cyc;
    @(posedge clock); #1;
    cmdValid = 1'b0; cmdOp = 3'd0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_q.size() == 0; i++) @(posedge clock);
    if (done_q.size() == 0) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic check_step(input string tag, input int acc, input int n_ticks, input int eff,
                            input int gen);
    int done_off;
    done_off = (n_ticks > 0) ? n_ticks * eff + 3 : 1;
    chk({tag, "_ticks"}, tick_q.size(), n_ticks);
    if (n_ticks > 0 && tick_q.size() > 0) chk({tag, "_first"}, tick_q[0] - acc, eff);
    for (int k = 1; k < tick_q.size() && k < n_ticks; k++)
      chk($sformatf("%s_space%0d", tag, k), tick_q[k] - tick_q[k-1], eff);
    chk({tag, "_done_cnt"}, done_q.size(), 1);
    if (done_q.size() > 0) chk({tag, "_done_at"}, done_q[0] - acc, done_off);
    chk({tag, "_gen"}, generation, gen);
    chk({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    int n;
    int per;
    int ticks;
    int eff;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation budget exhausted");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, nt, stop_cyc, exp_gen, eff, ticks, n, per, op;
    bit exp_stable, still;
    logic [17:0] exp_lv, pat;

    tbl[0] = '{n: 5, per: 10, ticks: 5, eff: 10};
    tbl[1] = '{n: 5, per: 0,  ticks: 5, eff: 3};
    tbl[2] = '{n: 1, per: 4,  ticks: 1, eff: 4};
    tbl[3] = '{n: 3, per: 3,  ticks: 3, eff: 3};
    tbl[4] = '{n: 0, per: 7,  ticks: 0, eff: 3};
    tbl[5] = '{n: 2, per: 2,  ticks: 2, eff: 3};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", cmdReady, 1);
    chk("rst_simclk", simClock, 0);
    chk("rst_load", load, 0);
    chk("rst_brst", boardReset, 0);
    chk("rst_en", enTimeStep, 0);
    chk("rst_lv", loadVals, 0);
    chk("rst_gen", generation, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", stepDone, 0);
    chk("rst_stable", stable, 0);
    reset = 1'b0;

    // CLEAR: boardReset for the two clocks following the accept
    clear_q();
    send(3'd1, 0, 0, 18'd0, acc);
    repeat (5) @(posedge clock);
    #1;
    chk("clr_len", brst_q.size(), 2);
    if (brst_q.size() == 2) begin
      chk("clr_start", brst_q[0] - acc, 1);
      chk("clr_end", brst_q[1] - acc, 2);
    end
    chk("clr_gen", generation, 0);
    chk("clr_busy", busy, 0);

    // STEP timing table
    still_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(3'd1, 0, 0, 18'd0, acc);
      clear_q();
      send(3'd3, tbl[i].n, tbl[i].per, 18'd0, acc);
      wait_done(2000);
      check_step($sformatf("row%0d", i), acc, tbl[i].ticks, tbl[i].eff, tbl[i].n);
    end

    // LOAD after generations have accumulated
    clear_q();
    send(3'd2, 0, 0, 18'h2AAAA, acc);
    repeat (6) @(posedge clock);
    #1;
    chk("ld_vals", loadVals, 18'h2AAAA);
    chk("ld_len", load_q.size(), 3);
    if (load_q.size() > 0) chk("ld_start", load_q[0] - acc, 1);
    chk("ld_pulses", tick_q.size(), 1);
    if (tick_q.size() > 0) chk("ld_pulse_at", tick_q[0] - acc, 2);
    chk("ld_gen", generation, 0);

    // RUN, stalled LOAD, then STOP in the middle of WAIT
    send(3'd1, 0, 0, 18'd0, acc);
    clear_q();
    send(3'd4, 0, 5, 18'd0, acc);
    nt = 0;
    for (int i = 0; i < 200 && nt < 3; i++) begin
      @(posedge clock); #1;
      if (simClock) nt++;
    end
    chk("run_reach3", nt, 3);
    cmdValid = 1'b1; cmdOp = 3'd2; patternIn = 18'h15555;
    #1;
    chk("run_ld_stall0", cmdReady, 0);
    @(posedge clock); #2;
    chk("run_ld_stall1", cmdReady, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    cmdOp = 3'd5;
    #1;
    chk("run_stop_ready", cmdReady, 1);
    stop_cyc = cyc;
    @(posedge clock); #1;
    cmdValid = 1'b0; cmdOp = 3'd0;
    repeat (15) @(posedge clock);
    #1;
    chk("run_ticks", tick_q.size(), 3);
    chk("run_done_cnt", done_q.size(), 1);
    if (done_q.size() > 0) chk("run_done_at", done_q[0] - stop_cyc, 1);
    chk("run_ready", cmdReady, 1);
    chk("run_busy", busy, 0);
    chk("run_gen", generation, 3);
    chk("run_lv_kept", loadVals, 18'h2AAAA);

    // RUN on a still-life board
    still_mode = 1'b1;
    send(3'd1, 0, 0, 18'd0, acc);
    clear_q();
    send(3'd4, 0, 4, 18'd0, acc);
`ifdef BOARD_CTRL_STABLE_STOP_EN
    wait_done(500);
    chk("still_ticks", tick_q.size(), 1);
    if (done_q.size() > 0) chk("still_done_at", done_q[0] - acc, 7);
    chk("still_stable", stable, 1);
    chk("still_busy", busy, 0);
`else
    repeat (24) @(posedge clock);
    #1;
    chk("still_running", busy, 1);
    chk("still_stable", stable, 1);
    chk("still_ticks_ge4", tick_q.size() >= 4, 1);
    send(3'd5, 0, 0, 18'd0, acc);
    wait_done(100);
    chk("still_stop_busy", busy, 0);
`endif
    still_mode = 1'b0;

    // Reset asserted during a TICK of a long STEP
    send(3'd3, 100, 5, 18'd0, acc);
    nt = 0;
    for (int i = 0; i < 200 && nt < 2; i++) begin
      @(posedge clock); #1;
      if (simClock) nt++;
    end
    chk("rsttick_reach", nt, 2);
    reset = 1'b1;
    #1;
    chk("rsttick_simclk", simClock, 0);
    chk("rsttick_en", enTimeStep, 0);
    chk("rsttick_busy", busy, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rsttick_gen", generation, 0);
    chk("rsttick_ready", cmdReady, 1);
    chk("rsttick_lv", loadVals, 0);

    // Generation counter wrap
    clear_q();
    send(3'd3, 255, 3, 18'd0, acc);
    wait_done(2000);
    chk("wrap_gen_max", generation, 255);
    clear_q();
    send(3'd3, 1, 3, 18'd0, acc);
    wait_done(100);
    chk("wrap_gen_zero", generation, 0);

    // Random command stream against the reference model
    exp_gen = 0; exp_stable = 1'b0; exp_lv = 18'd0;
    for (int it = 0; it < 14; it++) begin
      op = $urandom_range(0, 7);
      n = $urandom_range(0, 5);
      per = $urandom_range(0, 8);
      still = 1'($urandom_range(0, 1));
      pat = 18'($urandom);
      if (op == 4) op = 3;
      still_mode = still;
      clear_q();
      send(3'(op), n, per, pat, acc);
      if (op == 3) begin
        eff = (per < 3) ? 3 : per;
        ticks = n;
`ifdef BOARD_CTRL_STABLE_STOP_EN
        if (still && n > 0) ticks = 1;
`endif
        exp_gen = (exp_gen + ticks) % 256;
        if (ticks > 0) exp_stable = still;
        wait_done(200);
        check_step($sformatf("rnd%0d", it), acc, ticks, eff, exp_gen);
      end else begin
        if (op == 1) begin
          exp_gen = 0; exp_stable = 1'b0;
        end else if (op == 2) begin
          exp_gen = 0; exp_lv = pat;
        end
        repeat (6) @(posedge clock);
        #1;
        chk($sformatf("rnd%0d_gen", it), generation, exp_gen);
        chk($sformatf("rnd%0d_lv", it), loadVals, exp_lv);
        chk($sformatf("rnd%0d_busy", it), busy, 0);
        chk($sformatf("rnd%0d_nodone", it), done_q.size(), 0);
      end
      chk($sformatf("rnd%0d_stable", it), stable, exp_stable);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
